// File: rtl/gpu_cmd_frontend.sv
// Byte-bus command front end: assembles bus bytes into instruction words, queues them
// in a FIFO and releases one per cycle. Optional release gating via GPU_VBLANK_GATE_EN.
module gpu_cmd_frontend #(
    parameter int DATA_W      = 8,
    parameter int INSTR_BYTES = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                                  i_clk,
    input  logic                                  i_reset,
    input  logic                                  i_en,
    input  logic                                  i_we,
    input  logic [DATA_W-1:0]                     i_data,
    output logic                                  o_ack,
    output logic                                  o_busy,
    input  logic                                  i_vblank,
    input  logic                                  i_stall,
    output logic [DATA_W*INSTR_BYTES-1:0]         o_instruction,
    output logic                                  o_instruction_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       o_level
);
    localparam int IW = DATA_W * INSTR_BYTES;
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(INSTR_BYTES - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    logic [IW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [CW-1:0] count_q, count_d;
    logic [IW-1:0] asm_q, asm_d, word_s, instr_q, instr_d;
    logic          busy_q, busy_d, ack_q, ready_q;
    logic          accept_s, last_s, push_s, pop_s, gate_s;

`ifdef GPU_VBLANK_GATE_EN
    assign gate_s = i_vblank;
`else
    logic unused_vblank_s;
    assign gate_s          = 1'b1;
    assign unused_vblank_s = i_vblank;
`endif

    // Next-state: byte assembly, push/pop decisions, occupancy and output word.
    always_comb begin
        accept_s = i_en & ~busy_q;
        last_s   = (count_q == LAST_CNT);
        push_s   = accept_s & i_we & last_s;
        pop_s    = (level_q != '0) & ~i_stall & gate_s;

        // First byte of a word lands in the most significant lane.
        word_s = asm_q;
        for (int b = 0; b < INSTR_BYTES; b++) begin
            if (count_q == CW'(INSTR_BYTES - 1 - b)) begin
                word_s[b*DATA_W +: DATA_W] = i_data;
            end else begin
                word_s[b*DATA_W +: DATA_W] = asm_q[b*DATA_W +: DATA_W];
            end
        end

        if (accept_s) begin
            if (!i_we || last_s) begin
                count_d = '0;
                asm_d   = '0;
            end else begin
                count_d = count_q + CW'(1);
                asm_d   = word_s;
            end
        end else begin
            count_d = count_q;
            asm_d   = asm_q;
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        busy_d = (level_d == FULL_LVL);

        if (push_s) begin
            wptr_d = wptr_q + PW'(1);
        end else begin
            wptr_d = wptr_q;
        end

        if (pop_s) begin
            rptr_d  = rptr_q + PW'(1);
            instr_d = mem_q[rptr_q];
        end else begin
            rptr_d  = rptr_q;
            instr_d = instr_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_q <= '0;
            asm_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            ready_q <= 1'b0;
            instr_q <= '0;
        end else begin
            count_q <= count_d;
            asm_q   <= asm_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            busy_q  <= busy_d;
            ack_q   <= accept_s;
            ready_q <= pop_s;
            instr_q <= instr_d;
        end
    end

    // Queue storage; entries are only read once pushed, so no reset needed.
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            mem_q[wptr_q] <= word_s;
        end
    end

    assign o_ack               = ack_q;
    assign o_busy              = busy_q;
    assign o_instruction       = instr_q;
    assign o_instruction_ready = ready_q;
    assign o_level             = level_q;
endmodule
